// File: rtl/ahb_apb_pkg.sv
// Shared types and constants for the AHB-Lite to APB bridge.
// Holds FSM state encoding, HTRANS codes, peripheral map and HRESP.
package ahb_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WWAIT,
    SETUP,
    ACCESS
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [31:0] P0_BASE  = 32'h8000_0000;
  localparam logic [31:0] P0_LIMIT = 32'h83FF_FFFF;
  localparam logic [31:0] P1_BASE  = 32'h8400_0000;
  localparam logic [31:0] P1_LIMIT = 32'h87FF_FFFF;
  localparam logic [31:0] P2_BASE  = 32'h8800_0000;
  localparam logic [31:0] P2_LIMIT = 32'h8BFF_FFFF;

  localparam logic [1:0] HRESP_OKAY = 2'b00;

  function automatic logic in_range(
    input logic [31:0] a,
    input logic [31:0] base,
    input logic [31:0] limit
  );
    return (a >= base) && (a <= limit);
  endfunction

endpackage

// File: rtl/ahb2apb_decode.sv
// Address decoder: Haddr -> addr_hit and one-hot peripheral select.
// Ports: Haddr in; addr_hit, sel out (sel=000 when no hit).
module ahb2apb_decode
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] Haddr,
  output logic              addr_hit,
  output logic [2:0]        sel
);

  logic [31:0] a;
  assign a = 32'(Haddr);

  always_comb begin
    sel = 3'b000;
    unique case (1'b1)
      in_range(a, P0_BASE, P0_LIMIT): sel = 3'b001;
      in_range(a, P1_BASE, P1_LIMIT): sel = 3'b010;
      in_range(a, P2_BASE, P2_LIMIT): sel = 3'b100;
      default:                        sel = 3'b000;
    endcase
  end

  assign addr_hit = |sel;

endmodule

// File: rtl/ahb2apb_bridge.sv
// AHB-Lite slave to APB master bridge; one SETUP+ACCESS per AHB beat.
// Ports: AHB H* slave side, APB P* master side, Hclk/Hresetn.
module ahb2apb_bridge
  import ahb_apb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              Hwrite,
  input  logic              Hreadyin,
  input  logic [1:0]        Htrans,
  input  logic [2:0]        Hsize,
  input  logic [2:0]        Hburst,
  input  logic [DATA_W-1:0] Hwdata,
  input  logic [ADDR_W-1:0] Haddr,
  output logic [DATA_W-1:0] Hrdata,
  output logic [1:0]        Hresp,
  output logic              Hreadyout,
  input  logic [DATA_W-1:0] Prdata,
  output logic [DATA_W-1:0] Pwdata,
  output logic [ADDR_W-1:0] Paddr,
  output logic [2:0]        Pselx,
  output logic              Pwrite,
  output logic              Penable
);

  state_t      state, state_nxt;
  logic        addr_hit, valid;
  logic        accept, cap_wdata;
  logic [2:0]  dec_sel, sel_q;

  // Size/burst/seq-vs-nonseq do not affect a word-per-beat bridge.
  logic unused_in;
  assign unused_in = ^{Hsize, Hburst, Htrans[0]};

  ahb2apb_decode #(.ADDR_W(ADDR_W)) u_dec (
    .Haddr    (Haddr),
    .addr_hit (addr_hit),
    .sel      (dec_sel)
  );

  assign valid = Hreadyin & Htrans[1] & addr_hit;

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state  <= IDLE;
      Paddr  <= '0;
      Pwrite <= 1'b0;
      Pwdata <= '0;
      sel_q  <= 3'b000;
    end else begin
      state <= state_nxt;
      if (accept) begin
        Paddr  <= Haddr;
        Pwrite <= Hwrite;
        sel_q  <= dec_sel;
      end
      if (cap_wdata) Pwdata <= Hwdata;
    end
  end

  // Accepting in ACCESS chains beats with no idle APB cycle.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    cap_wdata = 1'b0;
    unique case (state)
      IDLE, ACCESS: begin
        if (valid) begin
          accept    = 1'b1;
          state_nxt = Hwrite ? WWAIT : SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      WWAIT: begin
        cap_wdata = 1'b1;
        state_nxt = SETUP;
      end
      SETUP:   state_nxt = ACCESS;
      default: state_nxt = IDLE;
    endcase
  end

  assign Penable   = (state == ACCESS);
  assign Pselx     = (state == SETUP || state == ACCESS) ? sel_q : 3'b000;
  assign Hreadyout = (state == IDLE || state == ACCESS);
  assign Hrdata    = (state == ACCESS && !Pwrite) ? Prdata : '0;
  assign Hresp     = HRESP_OKAY;

endmodule

// File: tb/tb_ahb2apb_bridge.sv
// Self-checking bench for ahb2apb_bridge: vector table plus sequences.
// Covers reset, single beats, decode edges, ignores, chaining, abort.
module tb_ahb2apb_bridge;

  logic        Hclk = 1'b0;
  logic        Hresetn;
  logic        Hwrite;
  logic        Hreadyin;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [2:0]  Hburst;
  logic [31:0] Hwdata;
  logic [31:0] Haddr;
  logic [31:0] Hrdata;
  logic [1:0]  Hresp;
  logic        Hreadyout;
  logic [31:0] Prdata;
  logic [31:0] Pwdata;
  logic [31:0] Paddr;
  logic [2:0]  Pselx;
  logic        Pwrite;
  logic        Penable;

  int checks = 0;
  int errors = 0;

  always #5 Hclk = ~Hclk;

  ahb2apb_bridge dut (
    .Hclk      (Hclk),
    .Hresetn   (Hresetn),
    .Hwrite    (Hwrite),
    .Hreadyin  (Hreadyin),
    .Htrans    (Htrans),
    .Hsize     (Hsize),
    .Hburst    (Hburst),
    .Hwdata    (Hwdata),
    .Haddr     (Haddr),
    .Hrdata    (Hrdata),
    .Hresp     (Hresp),
    .Hreadyout (Hreadyout),
    .Prdata    (Prdata),
    .Pwdata    (Pwdata),
    .Paddr     (Paddr),
    .Pselx     (Pselx),
    .Pwrite    (Pwrite),
    .Penable   (Penable)
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  sel;
    int          waits;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_bus();
    Htrans   = 2'b00;
    Hwrite   = 1'b0;
    Hreadyin = 1'b1;
  endtask

  // One beat from IDLE; follows it until ACCESS then checks return to IDLE.
  task automatic run_vec(input vec_t v, input string tag);
    int waits = 0;
    int setups = 0;
    bit done = 0;
    @(negedge Hclk);
    chk({tag, " ready_idle"}, 32'(Hreadyout), 32'd1);
    Haddr    = v.addr;
    Hwrite   = v.wr;
    Htrans   = 2'b10;
    Hreadyin = 1'b1;
    Prdata   = v.rdata;
    @(posedge Hclk);
    #1;
    Htrans = 2'b00;
    Hwdata = v.wdata;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge Hclk);
      if (!Hreadyout) waits++;
      if (Penable) begin
        done = 1;
        chk({tag, " pselx"},  32'(Pselx),  32'(v.sel));
        chk({tag, " paddr"},  Paddr,       v.addr);
        chk({tag, " pwrite"}, 32'(Pwrite), 32'(v.wr));
        if (v.wr) chk({tag, " pwdata"}, Pwdata, v.wdata);
        chk({tag, " hrdata"}, Hrdata, v.wr ? 32'h0 : v.rdata);
        chk({tag, " ready_acc"}, 32'(Hreadyout), 32'd1);
      end else if (Pselx != 3'b000) begin
        setups++;
        chk({tag, " setup_sel"}, 32'(Pselx), 32'(v.sel));
        chk({tag, " setup_hrdata"}, Hrdata, 32'h0);
      end
    end
    chk({tag, " reached_access"}, 32'(done), 32'd1);
    chk({tag, " wait_states"}, waits, v.waits);
    chk({tag, " setup_cycles"}, setups, 1);
    @(negedge Hclk);
    chk({tag, " back_idle_sel"}, 32'(Pselx), 32'd0);
    chk({tag, " back_idle_en"}, 32'(Penable), 32'd0);
    chk({tag, " hold_paddr"}, Paddr, v.addr);
  endtask

  task automatic run_ignored(input logic [1:0] tr, input logic [31:0] a,
                             input logic rdy, input string tag);
    @(negedge Hclk);
    Haddr    = a;
    Htrans   = tr;
    Hwrite   = 1'b1;
    Hreadyin = rdy;
    for (int i = 0; i < 3; i++) begin
      @(negedge Hclk);
      chk({tag, " sel"},   32'(Pselx),     32'd0);
      chk({tag, " ready"}, 32'(Hreadyout), 32'd1);
      chk({tag, " hresp"}, 32'(Hresp),     32'd0);
    end
    idle_bus();
  endtask

  initial begin
    vecs[0] = '{32'h8000_0010, 1'b1, 32'hDEAD_BEEF, 32'h0,         3'b001, 2};
    vecs[1] = '{32'h8400_0020, 1'b0, 32'h0,         32'h1234_5678, 3'b010, 1};
    vecs[2] = '{32'h8BFF_FFFC, 1'b1, 32'hCAFE_0001, 32'h0,         3'b100, 2};
    vecs[3] = '{32'h83FF_FFFC, 1'b0, 32'h0,         32'hA5A5_5A5A, 3'b001, 1};
    vecs[4] = '{32'h8800_0000, 1'b0, 32'h0,         32'h0BAD_F00D, 3'b100, 1};
    vecs[5] = '{32'h87FF_FFFC, 1'b1, 32'h1357_9BDF, 32'h0,         3'b010, 2};

    Hresetn  = 1'b0;
    Haddr    = 32'h0;
    Hwdata   = 32'h0;
    Prdata   = 32'hFFFF_FFFF;
    Hsize    = 3'b010;
    Hburst   = 3'b000;
    idle_bus();

    for (int i = 0; i < 2; i++) begin
      @(negedge Hclk);
      chk("rst ready", 32'(Hreadyout), 32'd1);
      chk("rst sel",   32'(Pselx),     32'd0);
      chk("rst en",    32'(Penable),   32'd0);
      chk("rst hresp", 32'(Hresp),     32'd0);
      chk("rst hrdata", Hrdata,        32'h0);
      chk("rst paddr", Paddr,          32'h0);
      chk("rst pwdata", Pwdata,        32'h0);
    end
    Hresetn = 1'b1;

    for (int i = 0; i < 6; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    run_ignored(2'b00, 32'h8000_0000, 1'b1, "ign_idle");
    run_ignored(2'b10, 32'h9000_0000, 1'b1, "ign_unmapped");
    run_ignored(2'b10, 32'h8C00_0000, 1'b1, "ign_above_p2");
    run_ignored(2'b10, 32'h7FFF_FFFC, 1'b1, "ign_below_p0");
    run_ignored(2'b01, 32'h8400_0000, 1'b1, "ign_busy");
    run_ignored(2'b10, 32'h8400_0000, 1'b0, "ign_notready");

    // Back-to-back: write then SEQ read presented during the write ACCESS.
    @(negedge Hclk);
    Haddr  = 32'h8800_0000;
    Hwrite = 1'b1;
    Htrans = 2'b10;
    Prdata = 32'h7777_8888;
    @(posedge Hclk);
    #1;
    Htrans = 2'b00;
    Hwdata = 32'hAAAA_5555;
    @(negedge Hclk);
    chk("b2b wwait ready", 32'(Hreadyout), 32'd0);
    chk("b2b wwait sel",   32'(Pselx),     32'd0);
    @(negedge Hclk);
    chk("b2b wsetup sel", 32'(Pselx),   32'd4);
    chk("b2b wsetup en",  32'(Penable), 32'd0);
    @(negedge Hclk);
    chk("b2b wacc en",     32'(Penable), 32'd1);
    chk("b2b wacc sel",    32'(Pselx),   32'd4);
    chk("b2b wacc pwdata", Pwdata,       32'hAAAA_5555);
    chk("b2b wacc hrdata", Hrdata,       32'h0);
    Haddr  = 32'h8800_0004;
    Hwrite = 1'b0;
    Htrans = 2'b11;
    @(negedge Hclk);
    chk("b2b rsetup sel",   32'(Pselx),     32'd4);
    chk("b2b rsetup en",    32'(Penable),   32'd0);
    chk("b2b rsetup paddr", Paddr,          32'h8800_0004);
    chk("b2b rsetup pwr",   32'(Pwrite),    32'd0);
    chk("b2b rsetup ready", 32'(Hreadyout), 32'd0);
    Htrans = 2'b00;
    @(negedge Hclk);
    chk("b2b racc en",     32'(Penable),   32'd1);
    chk("b2b racc hrdata", Hrdata,         32'h7777_8888);
    chk("b2b racc ready",  32'(Hreadyout), 32'd1);
    @(negedge Hclk);
    chk("b2b idle sel", 32'(Pselx), 32'd0);

    // Reset asserted in the middle of a SETUP cycle.
    Haddr  = 32'h8000_0040;
    Hwrite = 1'b0;
    Htrans = 2'b10;
    @(posedge Hclk);
    #1;
    Htrans = 2'b00;
    @(negedge Hclk);
    chk("abort pre sel", 32'(Pselx), 32'd1);
    #1;
    Hresetn = 1'b0;
    #1;
    chk("abort sel",   32'(Pselx),     32'd0);
    chk("abort en",    32'(Penable),   32'd0);
    chk("abort ready", 32'(Hreadyout), 32'd1);
    chk("abort paddr", Paddr,          32'h0);
    repeat (2) @(negedge Hclk);
    chk("abort hold en", 32'(Penable), 32'd0);
    Hresetn = 1'b1;
    @(negedge Hclk);
    chk("abort after sel",   32'(Pselx),     32'd0);
    chk("abort after ready", 32'(Hreadyout), 32'd1);
    run_vec(vecs[1], "post_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
